// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: forwarding select encoding,
// the in-flight slot record and the register-address width.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
    } sb_slot_t;

    // True when the slot will write register r; x0 never counts as a producer.
    function automatic logic slot_writes(sb_slot_t slot, logic [REG_ADDR_W-1:0] r);
        return slot.valid & slot.reg_write & (slot.rd == r) & (r != '0);
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    output logic [PERF_CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage core: tracks EX/MEM/WB destinations and
// drives stall, flush, EX forwarding and WB->ID bypass controls plus perf counters.
module hazard_scoreboard #(
    parameter int REG_ADDR_W   = 5,
    parameter int PERF_CNT_W   = 32,
    parameter int ID_WB_BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  ex_redirect,
    input  logic                  mem_stall,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  id_bypass_a,
    output logic                  id_bypass_b,
    output logic [PERF_CNT_W-1:0] perf_stall_cnt,
    output logic [PERF_CNT_W-1:0] perf_flush_cnt
);
    import hazard_pkg::*;

    sb_slot_t              ex_slot;
    sb_slot_t              mem_slot;
    sb_slot_t              wb_slot;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic                  load_use;
    fwd_sel_t              fwd_a_sel;
    fwd_sel_t              fwd_b_sel;

    // Slot shift; only valid bits are reset, payload fields are don't-care when invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_slot.valid  <= 1'b0;
            mem_slot.valid <= 1'b0;
            wb_slot.valid  <= 1'b0;
        end else if (!mem_stall) begin
            wb_slot           <= mem_slot;
            mem_slot          <= ex_slot;
            ex_slot.valid     <= id_valid & ~flush_e;
            ex_slot.rd        <= id_rd;
            ex_slot.reg_write <= id_reg_write;
            ex_slot.is_load   <= id_is_load;
            ex_rs1            <= id_rs1;
            ex_rs2            <= id_rs2;
        end
    end

    always_comb begin
        load_use = ex_slot.valid & ex_slot.is_load & (ex_slot.rd != '0) & id_valid &
                   ((id_uses_rs1 & (id_rs1 == ex_slot.rd)) |
                    (id_uses_rs2 & (id_rs2 == ex_slot.rd)));

        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        // A frozen EX cannot retire the redirect, so memory stall outranks it.
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
        end else if (ex_redirect) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_comb begin
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (ex_slot.valid) begin
            if (slot_writes(mem_slot, ex_rs1))     fwd_a_sel = FWD_MEM;
            else if (slot_writes(wb_slot, ex_rs1)) fwd_a_sel = FWD_WB;
            if (slot_writes(mem_slot, ex_rs2))     fwd_b_sel = FWD_MEM;
            else if (slot_writes(wb_slot, ex_rs2)) fwd_b_sel = FWD_WB;
        end
    end

    assign fwd_a       = fwd_a_sel;
    assign fwd_b       = fwd_b_sel;
    assign id_bypass_a = (ID_WB_BYPASS != 0) & slot_writes(wb_slot, id_rs1);
    assign id_bypass_b = (ID_WB_BYPASS != 0) & slot_writes(wb_slot, id_rs2);

    hazard_sat_counter #(.PERF_CNT_W(PERF_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_d),
        .count (perf_stall_cnt)
    );

    hazard_sat_counter #(.PERF_CNT_W(PERF_CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_d),
        .count (perf_flush_cnt)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; narrow perf counters so saturation is reachable.
module tb_hazard_scoreboard;

    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic          id_uses_rs1;
    logic          id_uses_rs2;
    logic [AW-1:0] id_rd;
    logic          id_reg_write;
    logic          id_is_load;
    logic          ex_redirect;
    logic          mem_stall;
    logic          stall_f;
    logic          stall_d;
    logic          stall_e;
    logic          flush_d;
    logic          flush_e;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          id_bypass_a;
    logic          id_bypass_b;
    logic [CW-1:0] perf_stall_cnt;
    logic [CW-1:0] perf_flush_cnt;

    int checks   = 0;
    int failures = 0;

    hazard_scoreboard #(
        .REG_ADDR_W   (AW),
        .PERF_CNT_W   (CW),
        .ID_WB_BYPASS (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .id_rd          (id_rd),
        .id_reg_write   (id_reg_write),
        .id_is_load     (id_is_load),
        .ex_redirect    (ex_redirect),
        .mem_stall      (mem_stall),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .stall_e        (stall_e),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .id_bypass_a    (id_bypass_a),
        .id_bypass_b    (id_bypass_b),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    wire [4:0] ctrl = {stall_f, stall_d, stall_e, flush_d, flush_e};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic u1, input logic u2, input logic [AW-1:0] rd,
                         input logic rw, input logic ld);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_uses_rs1  = u1;
        id_uses_rs2  = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_is_load   = ld;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        ex_redirect = 1'b0;
        mem_stall   = 1'b0;
        idle();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        ex_redirect = 1'b0;
        mem_stall   = 1'b0;
        idle();
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        check("rst_ctrl", ctrl, 5'b00000);
        check("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
        check("rst_bypass", {id_bypass_a, id_bypass_b}, 2'b00);
        check("rst_cnts", {perf_stall_cnt, perf_flush_cnt}, 8'h00);

        // lw x5,0(x1); add x6,x5,x1
        drive(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);
        #1; check("lw_issue_ctrl", ctrl, 5'b00000);
        cyc();
        drive(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0);
        #1; check("lu_ctrl", ctrl, 5'b11001);
        cyc();
        #1; check("lu_bubble_ctrl", ctrl, 5'b00000);
        cyc();
        idle();
        #1;
        check("lu_fwd", {fwd_a, fwd_b}, 4'b0100);
        check("lu_stall_cnt", perf_stall_cnt, 1);
        do_reset();

        // add x5,x1,x2; sub x7,x5,x5
        drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        cyc();
        drive(1, 5'd5, 5'd5, 1, 1, 5'd7, 1, 0);
        #1; check("raw_ctrl", ctrl, 5'b00000);
        cyc();
        idle();
        #1; check("raw_fwd", {fwd_a, fwd_b}, 4'b1010);
        do_reset();

        // add x5; nop; and x8,x5,x2; then ID reads x5 while add sits in WB
        drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        cyc();
        idle();
        cyc();
        drive(1, 5'd5, 5'd2, 1, 1, 5'd8, 1, 0);
        cyc();
        drive(1, 5'd3, 5'd5, 1, 1, 5'd9, 1, 0);
        #1;
        check("wb_fwd", {fwd_a, fwd_b}, 4'b0100);
        check("wb_bypass", {id_bypass_a, id_bypass_b}, 2'b01);
        check("wb_ctrl", ctrl, 5'b00000);
        do_reset();

        // Same with rd=x0, then a load into x0 followed by a reader of x0
        drive(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0);
        cyc();
        idle();
        cyc();
        drive(1, 5'd0, 5'd2, 1, 1, 5'd8, 1, 0);
        cyc();
        drive(1, 5'd0, 5'd0, 1, 1, 5'd9, 1, 0);
        #1;
        check("x0_fwd", {fwd_a, fwd_b}, 4'b0000);
        check("x0_bypass", {id_bypass_a, id_bypass_b}, 2'b00);
        drive(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1);
        cyc();
        drive(1, 5'd0, 5'd0, 1, 1, 5'd6, 1, 0);
        #1; check("x0_load_ctrl", ctrl, 5'b00000);
        do_reset();

        // Redirect coinciding with a load-use
        drive(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);
        cyc();
        drive(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0);
        ex_redirect = 1'b1;
        #1; check("redir_lu_ctrl", ctrl, 5'b00011);
        cyc();
        ex_redirect = 1'b0;
        idle();
        #1;
        check("redir_flush_cnt", perf_flush_cnt, 1);
        check("redir_stall_cnt", perf_stall_cnt, 0);
        check("redir_after_ctrl", ctrl, 5'b00000);
        do_reset();

        // Memory stall holding off a redirect for 3 cycles
        drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        cyc();
        drive(1, 5'd5, 5'd5, 1, 1, 5'd7, 1, 0);
        cyc();
        idle();
        mem_stall   = 1'b1;
        ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("ms_ctrl_%0d", i), ctrl, 5'b11100);
            check($sformatf("ms_frozen_fwd_%0d", i), fwd_a, 2'b10);
            cyc();
        end
        mem_stall = 1'b0;
        #1;
        check("ms_release_ctrl", ctrl, 5'b00011);
        check("ms_release_fwd", fwd_a, 2'b10);
        cyc();
        ex_redirect = 1'b0;
        #1;
        check("ms_stall_cnt", perf_stall_cnt, 3);
        check("ms_flush_cnt", perf_flush_cnt, 1);
        check("ms_bubble_fwd", {fwd_a, fwd_b}, 4'b0000);
        do_reset();

        // Saturation of the stall counter
        mem_stall = 1'b1;
        repeat (14) cyc();
        check("sat_count_14", perf_stall_cnt, 14);
        repeat (6) cyc();
        check("sat_hold", perf_stall_cnt, 4'hF);
        mem_stall = 1'b0;

        // Reset mid-operation with a load in EX and an add in MEM
        drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        cyc();
        drive(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);
        cyc();
        check("pre_rst_sat", perf_stall_cnt, 4'hF);
        reset = 1'b1;
        idle();
        cyc();
        reset = 1'b0;
        drive(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);
        #1;
        check("midrst_ctrl", ctrl, 5'b00000);
        check("midrst_fwd", {fwd_a, fwd_b}, 4'b0000);
        check("midrst_bypass", {id_bypass_a, id_bypass_b}, 2'b00);
        check("midrst_cnts", {perf_stall_cnt, perf_flush_cnt}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
